product_accumulator: RTL

Downstream consumer of the 32x32 Wallace-tree multiplier: accepts a programmed number of 64-bit products (`s`, `cout`) over a valid/ready handshake, sums them into a 64-bit accumulator and presents the total with a sticky overflow flag. It is the multiply-accumulate back end; the multiplier output registers feed `prod`/`prod_cout` directly.

---
 rtl/product_accumulator.sv | 121 ++++++++++++
 1 files changed

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - multiply-accumulate back end summing a programmed burst of 64-bit products
//
// Purpose:
//   Takes a burst of products from the multiplier's output registers over a
//   valid/ready handshake and sums them modulo 2^64. A sticky overflow flag
//   records any wrap of the sum and any product whose bit 64 was set. The
//   final total is held with out_valid until the consumer takes it.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset, highest priority
//   start      in   begin a burst (honoured only while idle)
//   len        in   number of products in the burst, captured with start
//   busy       out  block is not idle
//   in_valid   in   prod/prod_cout carry a valid product
//   in_ready   out  block accepts a product this cycle
//   prod       in   product bits [63:0]
//   prod_cout  in   product bit 64
//   acc        out  accumulated sum
//   ovf        out  sticky overflow for the current burst
//   out_valid  out  acc/ovf hold the final result
//   out_ready  in   consumer takes the result

module product_accumulator #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      prod,
    input  logic             prod_cout,
    output logic [63:0]      acc,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [63:0]      acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [LEN_W-1:0] rem_q, rem_d;

    // One extra bit captures the carry-out of the 64-bit add.
    logic [64:0] sum_full;
    logic        xfer;

    assign sum_full = {1'b0, acc_q} + {1'b0, prod};
    assign xfer     = in_valid && (state_q == S_ACCUM);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d = 64'd0;
                    ovf_d = 1'b0;
                    if (len != '0) begin
                        rem_d   = len;
                        state_d = S_ACCUM;
                    end else begin
                        rem_d   = '0;
                        state_d = S_DONE;
                    end
                end
            end
            S_ACCUM: begin
                if (xfer) begin
                    acc_d = sum_full[63:0];
                    ovf_d = ovf_q | sum_full[64] | prod_cout;
                    rem_d = rem_q - 1'b1;
                    if (rem_q == LEN_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // Result frozen until the consumer accepts it.
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= 64'd0;
            ovf_q   <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            rem_q   <= rem_d;
        end
    end

    // Handshake outputs decode the state register only, so neither
    // in_valid nor out_ready has a combinational path to them.
    assign busy      = (state_q != S_IDLE);
    assign in_ready  = (state_q == S_ACCUM);
    assign out_valid = (state_q == S_DONE);
    assign acc       = acc_q;
    assign ovf       = ovf_q;

endmodule
